// File: rtl/alu_pkg.sv
// Shared ALU-side types for the multi-cycle MIPS datapath.
// Holds ALU select, HI/LO op, output select and divider state.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MULT,
        ALU_MULTU,
        ALU_LUI
    } alu_sel_t;

    typedef enum logic [2:0] {
        HILO_NONE,
        HILO_MUL_WR,
        HILO_MTHI,
        HILO_MTLO,
        HILO_DIV,
        HILO_DIVU
    } hilo_op_t;

    typedef enum logic [1:0] {
        OUT_ALU,
        OUT_LO,
        OUT_HI
    } out_sel_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX
    } div_state_t;

    // LO value written by a divide by zero (sliced to WIDTH)
    localparam logic [63:0] DIV_DBZ_LO = '1;

endpackage

// File: rtl/hilo_unit_if.sv
// Bus between the ALU/controller and the HI/LO stage.
// Master drives operands and ops; slave returns registers.
interface hilo_unit_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_result_hi;
    logic             alu_out_en;
    hilo_op_t         hilo_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    out_sel_t         out_sel;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output alu_result, alu_result_hi, alu_out_en,
        output hilo_op, op_a, op_b, out_sel,
        input  out_data, hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  alu_result, alu_result_hi, alu_out_en,
        input  hilo_op, op_a, op_b, out_sel,
        output out_data, hi, lo, busy, done, div_by_zero
    );

endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Signed divides run on magnitudes and are fixed up in FIX.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             wr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign a_neg   = is_signed & a[WIDTH-1];
    assign b_neg   = is_signed & b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    // FSM: latch operands, iterate WIDTH times, then sign fix-up
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            a_raw  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state  <= DIV_RUN;
                        cnt    <= '0;
                        rem    <= '0;
                        quo    <= a_mag;
                        dvs    <= b_mag;
                        a_raw  <= a;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        b_zero <= (b == '0);
                        dbz    <= 1'b0;
                    end
                end
                DIV_RUN: begin
                    if (diff[WIDTH]) begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    state <= DIV_IDLE;
                    done  <= 1'b1;
                    dbz   <= b_zero;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign busy = (state != DIV_IDLE);
    assign wr   = (state == DIV_FIX);
    assign q    = b_zero ? DIV_DBZ_LO[WIDTH-1:0]
                         : (neg_q ? -quo : quo);
    assign r    = b_zero ? a_raw
                         : (neg_r ? -rem : rem);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO and ALU-out stage: MULT capture, MTHI/MTLO,
// divide result write-back and the register-file output mux.
module hilo_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    hilo_unit_if.slave bus
);

    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             div_busy;
    logic             div_done;
    logic             div_wr;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic             div_dbz;
    logic             div_start;
    logic             div_signed;

    assign div_signed = (bus.hilo_op == HILO_DIV);
    assign div_start  = !div_busy &&
                        ((bus.hilo_op == HILO_DIV) ||
                         (bus.hilo_op == HILO_DIVU));

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .is_signed(div_signed),
        .a        (bus.op_a),
        .b        (bus.op_b),
        .busy     (div_busy),
        .done     (div_done),
        .wr       (div_wr),
        .q        (div_q),
        .r        (div_r),
        .dbz      (div_dbz)
    );

    // ALU-out capture and HI/LO write arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            if (bus.alu_out_en) begin
                alu_out <= bus.alu_result;
            end
            if (div_wr) begin
                lo_r <= div_q;
                hi_r <= div_r;
            end else if (!div_busy) begin
                case (bus.hilo_op)
                    HILO_MUL_WR: begin
                        hi_r <= bus.alu_result_hi;
                        lo_r <= bus.alu_result;
                    end
                    HILO_MTHI: hi_r <= bus.op_a;
                    HILO_MTLO: lo_r <= bus.op_a;
                    default: ;
                endcase
            end
        end
    end

    // Write-back source for MFLO/MFHI or plain ALU results
    always_comb begin
        bus.out_data = alu_out;
        case (bus.out_sel)
            OUT_LO:  bus.out_data = lo_r;
            OUT_HI:  bus.out_data = hi_r;
            default: bus.out_data = alu_out;
        endcase
    end

    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.busy        = div_busy;
    assign bus.done        = div_done;
    assign bus.div_by_zero = div_dbz;

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequential HI/LO and ALU-output stage sitting directly downstream of the ALU in the multi-cycle MIPS datapath. It registers the ALU `result` into the ALU-out register and captures `{result_hi, result}` into HI/LO for MULT/MULTU. It also provides MTHI/MTLO writes and owns the iterative DIV/DIVU engine that writes quotient/remainder into LO/HI. A single output mux feeds the register-file write path with ALU-out, LO or HI (for MFLO/MFHI).

## Interface
Parameters:
- `WIDTH`, 32, datapath width; the divider counter spans `WIDTH` iterations.

Ports:
- `clk`  in  1  clock; every state element updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_result`  in  WIDTH  ALU `result` output.
- `alu_result_hi`  in  WIDTH  ALU `result_hi` output.
- `alu_out_en`  in  1  load `alu_result` into the ALU-out register.
- `hilo_op`  in  `hilo_op_t`  `HILO_NONE`, `HILO_MUL_WR`, `HILO_MTHI`, `HILO_MTLO`, `HILO_DIV`, `HILO_DIVU`.
- `op_a`  in  WIDTH  dividend, and the source for MTHI/MTLO.
- `op_b`  in  WIDTH  divisor.
- `out_sel`  in  `out_sel_t`  `OUT_ALU`, `OUT_LO`, `OUT_HI`.
- `out_data`  out  WIDTH  muxed output.
- `hi`, `lo`  out  WIDTH  direct register views.
- `busy`  out  1  divider running.
- `done`  out  1  one-cycle pulse after a divide writes HI/LO.
- `div_by_zero`  out  1  sticky flag, set by a divide with `op_b==0`; cleared at the next accepted divide.

## Operation
- Reset: `alu_out`, `hi`, `lo` = 0; `busy`, `done`, `div_by_zero` = 0; FSM in IDLE.
- ALU-out register: loads `alu_result` when `alu_out_en`, independent of FSM state. It also loads during a divide.
- `out_data` is combinational from `out_sel`: `alu_out` / `lo` / `hi`.
- In IDLE:
  - `HILO_MUL_WR`: `hi<=alu_result_hi`, `lo<=alu_result` on the same edge.
  - `HILO_MTHI`: `hi<=op_a`.
  - `HILO_MTLO`: `lo<=op_a`.
  - `HILO_DIV`/`HILO_DIVU`: latch operands, go to RUN.
- While `busy`: every non-NONE `hilo_op` is ignored; the controller stalls on `busy`. HI/LO hold their old values until FIX.
- FSM states:
  - IDLE to RUN on an accepted divide.
  - RUN: one restoring iteration per cycle for `WIDTH` cycles, counter 0..WIDTH-1. After the last iteration, go to FIX.
  - FIX: sign correction and HI/LO write, then back to IDLE.
- DIVU: unsigned restoring division. `lo`=quotient, `hi`=remainder.
- DIV operand handling:
  - Divide |a| by |b|.
  - Quotient is negated if the signs of a and b differ.
  - Remainder takes the sign of a.
  - The truncate-toward-zero results must match the MIPS `a = q*b + r` identity.
- DIV overflow case (−2^(W−1) / −1): `lo=0x8000_0000`, `hi=0`. This falls out naturally of the magnitude path and must not trap.
- Divide by zero, both DIV and DIVU:
  - Still runs the full latency.
  - Writes `lo=all ones` and `hi=op_a` (unmodified dividend).
  - Sets `div_by_zero`.

## Timing
- `HILO_MUL_WR`/`MTHI`/`MTLO`: 1-cycle latency; the new value is visible on `hi`/`lo`/`out_data` the cycle after the edge.
- Divide accepted at edge E0:
  - `busy`=1 from E0 through the cycle before E(WIDTH+1).
  - HI/LO are written at E(WIDTH+1): 33 edges for WIDTH=32.
  - `busy` falls and `done`=1 for exactly the cycle after E(WIDTH+1).
- Back-to-back: a new op may be issued in the `done` cycle (FSM is IDLE) and is accepted at the following edge.
- `rst` mid-divide: the next edge aborts to IDLE and all outputs take their reset values; no `done` pulse.
- `busy = (state != IDLE)`, driven straight from registered state; no combinational path from `hilo_op` to `busy`.

## Structure
- Add `hilo_op_t` and `out_sel_t` to `alu_pkg`, next to `alu_sel_t`.
- Add to `alu_pkg`: the divider state enum (`DIV_IDLE`, `DIV_RUN`, `DIV_FIX`) and the divide-by-zero LO constant.
- One sub-module, `seq_divider`, holds the FSM, counter, partial remainder/quotient and sign fix-up. Its ports are start/signed/a/b in; busy/done/q/r/dbz out.
- `hilo_unit` holds `alu_out`, HI/LO, write arbitration and the output mux.

## Test plan
- Reset, then `HILO_MUL_WR` with `alu_result_hi=0x1`, `alu_result=0x2` → next cycle `hi=0x1`, `lo=0x2`; with `out_sel=OUT_HI`, `out_data=0x1`.
- DIVU `op_a=100`, `op_b=7` → `busy` for 33 cycles, then `lo=14`, `hi=2`, `done` pulses once.
- DIV `op_a=-7`, `op_b=2` → `lo=0xFFFF_FFFD` (−3), `hi=0xFFFF_FFFF` (−1). DIV `op_a=0x8000_0000`, `op_b=-1` → `lo=0x8000_0000`, `hi=0`.
- DIV `op_a=5`, `op_b=0` → `lo=0xFFFF_FFFF`, `hi=5`, `div_by_zero=1`. The next valid divide clears the flag.
- `MTLO` issued while `busy` → ignored, `lo` unchanged until the divide result lands. `alu_out_en` during the divide still loads `alu_out`.
- `rst` asserted at iteration 10 of a divide → next cycle `busy=0`, `hi=lo=0`, and no `done` pulse follows.
